load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/lsu_align.sv | 24 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 encodings, response error codes and FSM states shared by the LSU
package load_store_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: moves the addressed lane of a load down to bit 0 and sign/zero extends it
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]                funct3,
  input  logic [XLEN-1:0]           raw,
  output logic [XLEN-1:0]           data
);
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;
  // shift by byte offset, keep the access size, fill upper bits with the sign for signed loads
  always_comb begin
    shifted = raw >> {offset, 3'b000};
    mask = funct3[1:0] == 2'd0 ? XLEN'(8'hFF) :
           funct3[1:0] == 2'd1 ? XLEN'(16'hFFFF) :
           funct3[1:0] == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
    sign = ~funct3[2] & (funct3[1:0] == 2'd0 ? shifted[7] :
                         funct3[1:0] == 2'd1 ? shifted[15] :
                         funct3[1:0] == 2'd2 ? shifted[31] : 1'b0);
    data = (shifted & mask) | (sign ? ~mask : '0);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between core request/response and a memory bus
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT + 2);
  lsu_state_t      state;
  logic [CW-1:0]   cnt;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic [OW-1:0]   off;
  logic            illegal;
  logic            misaligned;
  logic [7:0]      size_mask;
  logic [BW-1:0]   be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] ld_data;
  lsu_align #(.XLEN(XLEN)) u_align (
    .offset (off_q),
    .funct3 (f3_q),
    .raw    (mem_rdata),
    .data   (ld_data)
  );
  // decode the incoming request: legality, alignment, byte enables and lane-replicated store data
  always_comb begin
    off = req_addr[OW-1:0];
    illegal = req_funct3 == 3'b111 || (req_store && req_funct3 > F3_SD) ||
              (XLEN == 32 && (req_funct3 == F3_LD || req_funct3 == F3_LWU));
    misaligned = req_funct3[1:0] == 2'd1 ? off[0] :
                 req_funct3[1:0] == 2'd2 ? |off[1:0] :
                 req_funct3[1:0] == 2'd3 ? |off : 1'b0;
    size_mask = req_funct3[1:0] == 2'd0 ? 8'h01 :
                req_funct3[1:0] == 2'd1 ? 8'h03 :
                req_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    be = BW'(size_mask) << off;
    wdata = req_funct3[1:0] == 2'd0 ? {BW{req_wdata[7:0]}} :
            req_funct3[1:0] == 2'd1 ? {(XLEN/16){req_wdata[15:0]}} :
            req_funct3[1:0] == 2'd2 ? {(XLEN/32){req_wdata[31:0]}} : req_wdata;
  end
  // transaction FSM; every output is a register so it stays stable while a handshake is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      store_q   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      rsp_err   <= ERR_OK;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          store_q   <= req_store;
          f3_q      <= req_funct3;
          off_q     <= off;
          rsp_rd    <= req_rd;
          rsp_rdata <= '0;
          mem_we    <= req_store;
          mem_addr  <= {req_addr[XLEN-1:OW], OW'(0)};
          mem_be    <= be;
          mem_wdata <= wdata;
          if (illegal || misaligned) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            rsp_err   <= ERR_OK;
          end
        end
        ISSUE: if (mem_ready) begin
          state     <= WAIT;
          mem_valid <= 1'b0;
          cnt       <= '0;
        end
        WAIT: if (mem_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= store_q ? '0 : ld_data;
        end else if (TIMEOUT != 0 && cnt + 1'b1 == CW'(TIMEOUT)) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= ERR_TIMEOUT;
          rsp_rdata <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
